// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multi-cycle core's unified memory responder.
package mc_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_SHIFT = 2;
  localparam int REQ_ADDR_W = 32;  // widest request address the latched request can hold

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EXEC,
    RESP
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/mc_word_ram.sv
// Single-port synchronous word RAM: one write enable, registered read with its own enable.
module mc_word_ram
  import mc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // NOTE: the array and its read register have no reset so they map onto block RAM;
  // contents survive rst and consumers must qualify rdata_o themselves.
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Responder for the core's shared memory port: one outstanding request, configurable
// wait states, word-aligned access with misalignment/range errors.
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;

  logic              err;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Error is derived from the latched address, so it reflects the accept-time request.
  assign err = (req_q.addr[WORD_SHIFT-1:0] != '0) ||
               (req_q.addr[REQ_ADDR_W-1:WORD_SHIFT] >= (REQ_ADDR_W-WORD_SHIFT)'(DEPTH_WORDS));

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, addr: REQ_ADDR_W'(req_addr), wdata: req_wdata};
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : EXEC;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = EXEC;
      end
      EXEC: begin
        ram_we  = !err && req_q.we;
        ram_re  = !err && !req_q.we;
        err_d   = err;
        rd_ok_d = !err && !req_q.we;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  // A write committing on the same edge as rst is suppressed: reset wins.
  mc_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we && !rst),
    .re_i    (ram_re),
    .addr_i  (req_q.addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT]),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench: two responders (2 wait states and 0 wait states) driven by directed
// and random requests, checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_mc_mem_responder;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc [2];
  bit rand_rr [2];

  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  logic [31:0] mm0 [int];
  logic [31:0] mm1 [int];

  exp_t cur [2];
  bit   in_resp [2];

  mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32)) u_dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );

  mc_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int waits(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    if (d == 0) return exp_q0.size();
    return exp_q1.size();
  endfunction

  function automatic exp_t pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Reference memory: word array indexed by byte address / 4; unwritten words are unknown.
  function automatic exp_t model(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t e;
    int   idx;
    idx     = int'(addr / 4);
    e.rdata = 32'h0;
    e.chk   = 1'b1;
    e.acc   = 0;
    e.err   = (addr % 4 != 0) || (addr / 4 >= 32'(DEPTH));
    if (!e.err) begin
      if (we) begin
        if (d == 0) mm0[idx] = wdata; else mm1[idx] = wdata;
      end else if (d == 0) begin
        if (mm0.exists(idx)) e.rdata = mm0[idx]; else e.chk = 1'b0;
      end else begin
        if (mm1.exists(idx)) e.rdata = mm1[idx]; else e.chk = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic present(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept timeout", req_ready[d], 1'b1);
      req_valid[d] = 1'b0;
      return;
    end
    e     = model(d, we, addr, wdata);
    e.acc = cyc + 1;
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    last_acc[d] = e.acc;
    @(posedge clk);
    #1;
    // Scramble the request lines after accept; the latched request must be unaffected.
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || resp_valid[d]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain timeout", 32'(qsize(d)), 32'h0);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, " req_ready"}, req_ready[d], 1'b1);
    check({tag, " resp_valid"}, resp_valid[d], 1'b0);
    check({tag, " resp_rdata"}, resp_rdata[d], 32'h0);
    check({tag, " resp_err"}, resp_err[d], 1'b0);
    check({tag, " busy"}, busy[d], 1'b0);
  endtask

  // Accept a write, then pulse rst on the following edge; no response may appear.
  task automatic abort(input int d, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = addr; req_wdata[d] = wdata;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("abort accept timeout", req_ready[d], 1'b1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    @(negedge clk) rst[d] = 1'b1;
    @(negedge clk) rst[d] = 1'b0;
    check_reset_outputs(d, "after abort");
    repeat (waits(d) + 4) begin
      @(negedge clk);
      check("abort no resp_valid", resp_valid[d], 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard when a response first appears, then checks it stays stable.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        in_resp[d] = 1'b0;
      end else if (resp_valid[d]) begin
        if (!in_resp[d]) begin
          in_resp[d] = 1'b1;
          if (qsize(d) == 0) begin
            check("spurious resp_valid", resp_valid[d], 1'b0);
            cur[d].chk = 1'b0;
            cur[d].err = resp_err[d];
          end else begin
            cur[d] = pop(d);
            check("resp latency", 32'(cyc + 1 - cur[d].acc), 32'(waits(d) + 2));
            check("resp err", resp_err[d], cur[d].err);
            if (cur[d].chk) check("resp rdata", resp_rdata[d], cur[d].rdata);
          end
        end else begin
          check("held resp err", resp_err[d], cur[d].err);
          if (cur[d].chk) check("held resp rdata", resp_rdata[d], cur[d].rdata);
        end
      end else begin
        in_resp[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rand_rr[d]) resp_ready[d] = ($urandom_range(3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int consume;
    int n;
    logic [31:0] a;
    int idx;
    rst = '1; req_valid = '0; req_we = '0; resp_ready = '1;
    rand_rr[0] = 1'b0; rand_rr[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; in_resp[d] = 1'b0; last_acc[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset w2");
    check_reset_outputs(1, "reset w0");
    rst = '0;

    // Write then read back with 2 wait states; back-to-back accepts are W+3 apart.
    present(0, 1'b1, 32'h40, 32'hDEADBEEF);
    prev = last_acc[0];
    present(0, 1'b0, 32'h40, 32'h0);
    check("spacing w2", 32'(last_acc[0] - prev), 32'd5);
    drain(0);

    // Error cases: misaligned, out of range, and errored writes leaving RAM untouched.
    present(0, 1'b1, 32'h0, 32'h11111111);
    present(0, 1'b1, 32'hFFC, 32'h22222222);
    present(0, 1'b0, 32'h42, 32'h0);
    present(0, 1'b0, 32'h1000, 32'h0);
    present(0, 1'b1, 32'h1000, 32'h33333333);
    present(0, 1'b1, 32'h2, 32'h44444444);
    present(0, 1'b0, 32'h0, 32'h0);
    present(0, 1'b0, 32'hFFC, 32'h0);
    drain(0);

    // Back-pressure: response held while a new request waits.
    resp_ready[0] = 1'b0;
    present(0, 1'b0, 32'h40, 32'h0);
    n = 0;
    while (!resp_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold resp arrives", resp_valid[0], 1'b1);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'hFFC; req_wdata[0] = 32'h0;
    repeat (5) begin
      @(negedge clk);
      check("hold req_ready", req_ready[0], 1'b0);
      check("hold resp_valid", resp_valid[0], 1'b1);
      check("hold busy", busy[0], 1'b1);
    end
    resp_ready[0] = 1'b1;
    consume = cyc + 1;
    present(0, 1'b0, 32'hFFC, 32'h0);
    check("accept after release", 32'(last_acc[0] - consume), 32'd1);
    drain(0);

    // Zero wait states.
    present(1, 1'b1, 32'h0, 32'h00000013);
    prev = last_acc[1];
    present(1, 1'b0, 32'h0, 32'h0);
    check("spacing w0", 32'(last_acc[1] - prev), 32'd3);
    drain(1);

    // Reset during WAIT (2 wait states) and during EXEC (0 wait states).
    for (int d = 0; d < 2; d++) begin
      present(d, 1'b1, 32'h8, 32'hAAAA5555);
      present(d, 1'b0, 32'h8, 32'h0);
      drain(d);
      abort(d, 32'h8, 32'h12345678);
      present(d, 1'b0, 32'h8, 32'h0);
      drain(d);
    end

    // Random traffic with random back-pressure over a preloaded low/high window.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) present(d, 1'b1, 32'(i * 4), $urandom);
      for (int i = 1016; i < 1024; i++) present(d, 1'b1, 32'(i * 4), $urandom);
      rand_rr[d] = 1'b1;
      for (int k = 0; k < 40; k++) begin
        idx = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : 1016 + int'($urandom_range(7));
        case ($urandom_range(9))
          0, 1, 2, 3, 4, 5: a = 32'(idx * 4);
          6, 7:             a = 32'(idx * 4) + 32'($urandom_range(3, 1));
          default:          a = $urandom | 32'h1000;
        endcase
        present(d, 1'($urandom), a, $urandom);
      end
      rand_rr[d] = 1'b0;
      @(negedge clk);
      resp_ready[d] = 1'b1;
      drain(d);
    end

    check("scoreboard empty w2", 32'(exp_q0.size()), 32'h0);
    check("scoreboard empty w0", 32'(exp_q1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
